// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared types and constants for the program-counter
//               interrupt/reset sequencer: sequencer states, the causes that
//               can be granted, default vector addresses, and the bit
//               positions of the status-register bits that a push alters.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PUSH_H = 3'd1,
        S_PUSH_L = 3'd2,
        S_PUSH_P = 3'd3,
        S_VEC_L  = 3'd4,
        S_VEC_H  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        C_RST = 2'd0,
        C_NMI = 2'd1,
        C_IRQ = 2'd2,
        C_BRK = 2'd3
    } cause_t;

    localparam logic [15:0] VEC_NMI_ADDR = 16'hFFFA;
    localparam logic [15:0] VEC_RST_ADDR = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_ADDR = 16'hFFFE;

    // Status-register bit positions touched by the P push
    localparam int P_B_BIT = 4;
    localparam int P_U_BIT = 5;

endpackage
`default_nettype wire

// File: rtl/sys_if.sv
`default_nettype none
// ============================================================================
// Module      : sys_if
// Description : Clock and reset bundle shared by the sequencer.
// Ports       : clk     - clock
//               n_reset - reset, synchronous, active-low
// Revision    : 1.0 - initial release
// ============================================================================
interface sys_if;
    logic clk;
    logic n_reset;

    modport dut (input clk, input n_reset);
endinterface
`default_nettype wire

// File: rtl/pc_seq_nmi_edge.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_nmi_edge
// Description : NMI falling-edge detector. Registers nmi_n and holds a
//               pending flag that is set on a 1->0 transition and cleared
//               only on request. A held-low line never re-triggers.
// Ports       : clk      - clock
//               n_reset  - synchronous active-low reset
//               nmi_n    - raw NMI line
//               clr      - clear the pending flag (NMI vector taken)
//               nmi_pend - NMI edge seen and not yet serviced
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_nmi_edge (
    input  logic clk,
    input  logic n_reset,
    input  logic nmi_n,
    input  logic clr,
    output logic nmi_pend
);

    logic r_nmi_q;
    logic w_fall;

    assign w_fall = r_nmi_q & ~nmi_n;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_nmi_q  <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            r_nmi_q  <= nmi_n;
            // A fresh edge coinciding with a clear is a new request and wins
            nmi_pend <= w_fall | (nmi_pend & ~clr);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq
// Description : Interrupt/reset sequencer for the CPU program counter.
//               Arbitrates reset, NMI, IRQ and BRK at instruction
//               boundaries, runs the three stack pushes and the two vector
//               fetches, and drives the PC byte load/output enables.
// Ports       : sys            - clock / synchronous active-low reset
//               nmi_n, irq_n   - interrupt lines (edge / level)
//               brk, i_flag    - BRK opcode flag, interrupt-disable flag
//               insn_boundary  - decoder may yield this cycle
//               busy, done     - sequence status
//               pc_*           - PC register controls and load byte
//               dbus, sp, p_in - PC byte, stack pointer, status register
//               sp_dec, set_i  - SP decrement, set interrupt-disable
//               bus_*          - system bus master signals
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int                 ADDR_N     = 16,
    parameter int                 DATA_N     = 8,
    parameter logic [ADDR_N-1:0]  VEC_NMI    = VEC_NMI_ADDR,
    parameter logic [ADDR_N-1:0]  VEC_RST    = VEC_RST_ADDR,
    parameter logic [ADDR_N-1:0]  VEC_IRQ    = VEC_IRQ_ADDR,
    parameter logic [7:0]         STACK_PAGE = 8'h01
) (
    sys_if.dut                 sys,
    input  logic               nmi_n,
    input  logic               irq_n,
    input  logic               brk,
    input  logic               i_flag,
    input  logic               insn_boundary,
    output logic               busy,
    output logic               done,
    output logic               pc_addr_oe,
    output logic               pc_oeh,
    output logic               pc_oel,
    output logic               pc_weh,
    output logic               pc_wel,
    output logic [DATA_N-1:0]  pc_in,
    input  logic [DATA_N-1:0]  dbus,
    input  logic [DATA_N-1:0]  sp,
    output logic               sp_dec,
    input  logic [DATA_N-1:0]  p_in,
    output logic               set_i,
    output logic [ADDR_N-1:0]  bus_addr,
    output logic               bus_addr_oe,
    output logic               bus_we,
    output logic [DATA_N-1:0]  bus_wdata,
    input  logic [DATA_N-1:0]  bus_rdata,
    input  logic               bus_ready
);

    state_t             r_state,     w_state_nx;
    cause_t             r_cause,     w_cause_nx;
    logic [ADDR_N-1:0]  r_vec,       w_vec_nx;
    logic               r_rst_pend,  w_rst_pend_nx;
    logic               w_nmi_pend;
    logic               w_nmi_clr;
    logic [ADDR_N-1:0]  w_stack_addr;
    logic [DATA_N-1:0]  w_p_push;

    pc_seq_nmi_edge u_nmi_edge (
        .clk      (sys.clk),
        .n_reset  (sys.n_reset),
        .nmi_n    (nmi_n),
        .clr      (w_nmi_clr),
        .nmi_pend (w_nmi_pend)
    );

    assign w_stack_addr = ADDR_N'({STACK_PAGE, sp});

    always_ff @(posedge sys.clk) begin
        if (!sys.n_reset) begin
            r_state    <= S_IDLE;
            r_cause    <= C_RST;
            r_vec      <= VEC_RST;
            r_rst_pend <= 1'b1;
        end else begin
            r_state    <= w_state_nx;
            r_cause    <= w_cause_nx;
            r_vec      <= w_vec_nx;
            r_rst_pend <= w_rst_pend_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cause_nx    = r_cause;
        w_vec_nx      = r_vec;
        w_rst_pend_nx = r_rst_pend;
        w_nmi_clr     = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        pc_oeh        = 1'b0;
        pc_oel        = 1'b0;
        pc_weh        = 1'b0;
        pc_wel        = 1'b0;
        pc_in         = '0;
        sp_dec        = 1'b0;
        set_i         = 1'b0;
        bus_addr      = '0;
        bus_addr_oe   = 1'b0;
        bus_we        = 1'b0;
        bus_wdata     = '0;

        // Pushed status always has U set; B distinguishes BRK from hardware
        w_p_push          = p_in;
        w_p_push[P_U_BIT] = 1'b1;
        w_p_push[P_B_BIT] = (r_cause == C_BRK);

        case (r_state)
            S_IDLE: begin
                // After reset the block stays busy until the reset vector is loaded
                busy = r_rst_pend;
                if (r_rst_pend) begin
                    w_state_nx    = S_VEC_L;
                    w_cause_nx    = C_RST;
                    w_vec_nx      = VEC_RST;
                    w_rst_pend_nx = 1'b0;
                end else if (insn_boundary) begin
                    if (w_nmi_pend) begin
                        w_state_nx = S_PUSH_H;
                        w_cause_nx = C_NMI;
                        w_vec_nx   = VEC_NMI;
                        w_nmi_clr  = 1'b1;
                    end else if (!irq_n && !i_flag) begin
                        w_state_nx = S_PUSH_H;
                        w_cause_nx = C_IRQ;
                        w_vec_nx   = VEC_IRQ;
                    end else if (brk) begin
                        w_state_nx = S_PUSH_H;
                        w_cause_nx = C_BRK;
                        w_vec_nx   = VEC_IRQ;
                    end
                end
            end
            S_PUSH_H, S_PUSH_L, S_PUSH_P: begin
                bus_addr    = w_stack_addr;
                bus_addr_oe = 1'b1;
                bus_we      = 1'b1;
                sp_dec      = bus_ready;
                if (r_state == S_PUSH_H) begin
                    pc_oeh    = 1'b1;
                    bus_wdata = dbus;
                    if (bus_ready) w_state_nx = S_PUSH_L;
                end else if (r_state == S_PUSH_L) begin
                    pc_oel    = 1'b1;
                    bus_wdata = dbus;
                    if (bus_ready) w_state_nx = S_PUSH_P;
                end else begin
                    bus_wdata = w_p_push;
                    if (bus_ready) begin
                        w_state_nx = S_VEC_L;
                        // An NMI arriving during an IRQ/BRK push takes over
                        // the vector; an NMI during an NMI push stays pending
                        if (w_nmi_pend && (r_cause != C_NMI)) begin
                            w_vec_nx  = VEC_NMI;
                            w_nmi_clr = 1'b1;
                        end
                    end
                end
            end
            S_VEC_L: begin
                bus_addr    = r_vec;
                bus_addr_oe = 1'b1;
                if (bus_ready) begin
                    pc_wel     = 1'b1;
                    pc_in      = bus_rdata;
                    set_i      = 1'b1;
                    w_state_nx = S_VEC_H;
                end
            end
            S_VEC_H: begin
                bus_addr    = r_vec + ADDR_N'(1);
                bus_addr_oe = 1'b1;
                if (bus_ready) begin
                    pc_weh     = 1'b1;
                    pc_in      = bus_rdata;
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b0;
                done       = 1'b1;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        pc_addr_oe = ~busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_seq
// Description : Self-checking bench for pc_seq. Emulates the PC register,
//               stack pointer and vector ROM around the sequencer, logs the
//               bus cycles and PC loads it observes, and compares them with
//               the transaction list expected from the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_seq;

    sys_if sys ();

    logic        nmi_n, irq_n, brk, i_flag, insn_boundary;
    logic        busy, done, pc_addr_oe, pc_oeh, pc_oel, pc_weh, pc_wel;
    logic [7:0]  pc_in, dbus, sp, p_in, bus_wdata, bus_rdata;
    logic        sp_dec, set_i, bus_addr_oe, bus_we, bus_ready;
    logic [15:0] bus_addr;

    int checks = 0;
    int errors = 0;

    // Bench-side models of the surrounding datapath
    logic [7:0]  vb [0:5];          // vector ROM at FFFA..FFFF
    logic [15:0] pc_reg;
    logic [7:0]  sp_reg;
    int          cyc;
    int          done_at, n_done, n_spdec, n_seti;
    logic [23:0] wr_q [$];          // {addr, data} of completed writes
    logic [15:0] rd_q [$];          // addr of completed reads
    logic [8:0]  pcw_q [$];         // {hi_byte, data} of PC loads
    logic        hold_chk;
    logic [15:0] hold_addr;
    logic        hold_we;

    pc_seq dut (
        .sys           (sys),
        .nmi_n         (nmi_n),
        .irq_n         (irq_n),
        .brk           (brk),
        .i_flag        (i_flag),
        .insn_boundary (insn_boundary),
        .busy          (busy),
        .done          (done),
        .pc_addr_oe    (pc_addr_oe),
        .pc_oeh        (pc_oeh),
        .pc_oel        (pc_oel),
        .pc_weh        (pc_weh),
        .pc_wel        (pc_wel),
        .pc_in         (pc_in),
        .dbus          (dbus),
        .sp            (sp),
        .sp_dec        (sp_dec),
        .p_in          (p_in),
        .set_i         (set_i),
        .bus_addr      (bus_addr),
        .bus_addr_oe   (bus_addr_oe),
        .bus_we        (bus_we),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ready     (bus_ready)
    );

    initial sys.clk = 1'b0;
    always #5 sys.clk = ~sys.clk;

    function automatic logic [7:0] vread(input logic [15:0] a);
        logic [15:0] off;
        if (a >= 16'hFFFA) begin
            off = a - 16'hFFFA;
            return vb[int'(off)];
        end
        return 8'hEE;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_q.delete();
        rd_q.delete();
        pcw_q.delete();
        done_at  = -1;
        n_done   = 0;
        n_spdec  = 0;
        n_seti   = 0;
        cyc      = 0;
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic step();
        #1;
        bus_rdata = vread(bus_addr);
        dbus = pc_oeh ? pc_reg[15:8] : (pc_oel ? pc_reg[7:0] : 8'h00);
        #1;
        if (hold_chk) begin
            chk("hold_addr", 32'(bus_addr), 32'(hold_addr));
            chk("hold_ctl", 32'({bus_addr_oe, bus_we, sp_dec, pc_wel, pc_weh, set_i, done}),
                32'({1'b1, hold_we, 5'b00000}));
        end
        if (bus_addr_oe && bus_ready) begin
            if (bus_we) wr_q.push_back({bus_addr, bus_wdata});
            else        rd_q.push_back(bus_addr);
        end
        if (pc_wel) begin pcw_q.push_back({1'b0, pc_in}); pc_reg[7:0]  = pc_in; end
        if (pc_weh) begin pcw_q.push_back({1'b1, pc_in}); pc_reg[15:8] = pc_in; end
        if (sp_dec) begin n_spdec++; sp_reg = sp_reg - 8'd1; end
        if (set_i)  n_seti++;
        if (done)   begin n_done++; done_at = cyc; end
        cyc++;
        @(negedge sys.clk);
        sp = sp_reg;
    endtask

    task automatic run_reset(input string tag);
        sys.n_reset = 1'b0;
        bus_ready = 1'b1; insn_boundary = 1'b0; irq_n = 1'b1; brk = 1'b0; nmi_n = 1'b1;
        hold_chk = 1'b0;
        vb[2] = 8'h34;
        vb[3] = 8'h12;
        step();
        step();
        #1;
        chk({tag, "_rst_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rst_strobes"}, 32'({done, pc_addr_oe, pc_oeh, pc_oel, pc_weh, pc_wel,
                                        sp_dec, set_i, bus_addr_oe, bus_we}), 32'd0);
        chk({tag, "_rst_data"}, {bus_addr, bus_wdata, pc_in}, 32'd0);
        step();
        sys.n_reset = 1'b1;
        clear_logs();
        while (n_done == 0 && cyc < 12) step();
        chk({tag, "_rvec_done_at"}, 32'(done_at), 32'd3);
        chk({tag, "_rvec_pcw_n"}, 32'(pcw_q.size()), 32'd2);
        chk({tag, "_rvec_pcw_lo"}, (pcw_q.size() > 0) ? 32'(pcw_q[0]) : 32'hX, 32'({1'b0, 8'h34}));
        chk({tag, "_rvec_pcw_hi"}, (pcw_q.size() > 1) ? 32'(pcw_q[1]) : 32'hX, 32'({1'b1, 8'h12}));
        chk({tag, "_rvec_writes"}, 32'(wr_q.size()), 32'd0);
        chk({tag, "_rvec_rd0"}, (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hX, 32'hFFFC);
        chk({tag, "_rvec_rd1"}, (rd_q.size() > 1) ? 32'(rd_q[1]) : 32'hX, 32'hFFFD);
        chk({tag, "_rvec_spdec"}, 32'(n_spdec), 32'd0);
    endtask

    // kind: 0 IRQ, 1 BRK (IRQ masked), 2 NMI. nmi_at: cycle (from grant) at
    // which nmi_n falls, -1 for none. One run of len not-ready cycles is
    // inserted at bus stage wstage (1..5).
    task automatic run_seq(input int kind, input int nmi_at, input int wstage,
                           input int len, input bit fixed);
        logic [15:0] pc0, vec;
        logic [7:0]  sp0, p0, pexp;
        logic [23:0] ew [3];
        bit          hijack;
        int          push_p_end;

        for (int i = 0; i < 6; i++) vb[i] = 8'($urandom);
        pc0 = 16'($urandom);
        sp0 = fixed ? 8'hFD : 8'($urandom);
        p0  = fixed ? 8'h04 : 8'($urandom);
        pc_reg = pc0; sp_reg = sp0; sp = sp0; p_in = p0;

        nmi_n = 1'b1; insn_boundary = 1'b0; irq_n = 1'b1; brk = 1'b0;
        bus_ready = 1'b1; hold_chk = 1'b0;
        step();
        if (kind == 2) begin
            nmi_n = 1'b0;
            step();
        end

        // Expected transactions from the sequencing rules
        push_p_end = 3 + ((wstage <= 3) ? len : 0);
        hijack = (kind != 2) && (nmi_at >= 0) && (nmi_at + 1 <= push_p_end);
        vec  = (kind == 2 || hijack) ? 16'hFFFA : 16'hFFFE;
        pexp = (p0 & 8'hEF) | 8'h20 | ((kind == 1) ? 8'h10 : 8'h00);
        ew[0] = {8'h01, sp0,         pc0[15:8]};
        ew[1] = {8'h01, sp0 - 8'd1,  pc0[7:0]};
        ew[2] = {8'h01, sp0 - 8'd2,  pexp};

        case (kind)
            0:       begin irq_n = 1'b0; i_flag = 1'b0; brk = 1'($urandom); end
            1:       begin irq_n = 1'($urandom); i_flag = 1'b1; brk = 1'b1; end
            default: begin irq_n = 1'($urandom); i_flag = 1'($urandom); brk = 1'($urandom); end
        endcase

        clear_logs();
        while (n_done == 0 && cyc < 40) begin
            insn_boundary = (cyc == 0);
            if (cyc == 1) begin irq_n = 1'b1; brk = 1'b0; end
            if (nmi_at >= 0 && cyc >= nmi_at) nmi_n = 1'b0;
            bus_ready = !(len > 0 && cyc >= wstage && cyc < wstage + len);
            hold_chk  = !bus_ready;
            hold_we   = (wstage <= 3);
            hold_addr = (wstage <= 3) ? {8'h01, sp0 - 8'(wstage - 1)}
                      : ((wstage == 4) ? vec : vec + 16'd1);
            step();
        end
        hold_chk = 1'b0; bus_ready = 1'b1;

        chk("seq_done_at", 32'(done_at), 32'(6 + len));
        chk("seq_done_n", 32'(n_done), 32'd1);
        chk("seq_wr_n", 32'(wr_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("seq_wr", (wr_q.size() > i) ? 32'(wr_q[i]) : 32'hX, 32'(ew[i]));
        chk("seq_rd_n", 32'(rd_q.size()), 32'd2);
        chk("seq_rd0", (rd_q.size() > 0) ? 32'(rd_q[0]) : 32'hX, 32'(vec));
        chk("seq_rd1", (rd_q.size() > 1) ? 32'(rd_q[1]) : 32'hX, 32'(vec + 16'd1));
        chk("seq_pc", 32'(pc_reg), 32'({vread(vec + 16'd1), vread(vec)}));
        chk("seq_pcw_order", (pcw_q.size() == 2) ? 32'({pcw_q[0][8], pcw_q[1][8]}) : 32'hX, 32'b01);
        chk("seq_spdec", 32'(n_spdec), 32'd3);
        chk("seq_seti", 32'(n_seti), 32'd1);

        // No leftover or re-triggered request may start another sequence
        insn_boundary = 1'b1;
        repeat (4) begin
            #1;
            chk("seq_idle_busy", 32'(busy), 32'd0);
            step();
        end
        insn_boundary = 1'b0;
    endtask

    initial begin
        nmi_n = 1'b1; irq_n = 1'b1; brk = 1'b0; i_flag = 1'b0; insn_boundary = 1'b0;
        dbus = 8'h00; sp = 8'hFD; p_in = 8'h00; bus_rdata = 8'h00; bus_ready = 1'b1;
        sys.n_reset = 1'b0; hold_chk = 1'b0; hold_we = 1'b0; hold_addr = 16'h0;
        pc_reg = 16'h0; sp_reg = 8'hFD;
        for (int i = 0; i < 6; i++) vb[i] = 8'h00;
        @(negedge sys.clk);

        run_reset("por");
        run_seq(0, -1, 1, 0, 1'b1);    // IRQ, sp=FD, p=04
        run_seq(1, -1, 1, 0, 1'b0);    // BRK with IRQ masked
        run_seq(0,  2, 1, 0, 1'b0);    // NMI edge during PUSH_L of an IRQ
        run_seq(0, -1, 4, 2, 1'b0);    // two wait states in VEC_L
        run_seq(2, -1, 1, 0, 1'b0);    // plain NMI

        // Masked IRQ alone never gets a grant
        irq_n = 1'b0; i_flag = 1'b1; brk = 1'b0; insn_boundary = 1'b1; nmi_n = 1'b1;
        step();
        repeat (5) begin
            #1;
            chk("masked_busy", 32'({busy, bus_addr_oe}), 32'd0);
            step();
        end
        irq_n = 1'b1; insn_boundary = 1'b0; i_flag = 1'b0;

        for (int n = 0; n < 8; n++)
            run_seq(int'($urandom_range(0, 2)),
                    ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2)) : -1,
                    int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'b0);

        // Reset during VEC_L aborts the sequence with no further PC loads
        clear_logs();
        irq_n = 1'b0; i_flag = 1'b0; insn_boundary = 1'b1; bus_ready = 1'b1;
        step();
        insn_boundary = 1'b0; irq_n = 1'b1;
        repeat (3) step();
        sys.n_reset = 1'b0;
        step();
        #1;
        chk("abort_state", 32'({busy, pc_wel, pc_weh, bus_addr_oe, done}), 32'b10000);
        run_reset("abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_seq.md
# pc_seq

Interrupt/reset sequencer for the CPU program counter. Arbitrates between reset, NMI, IRQ and BRK causes at instruction boundaries. Runs the stack-push and vector-fetch bus cycles, and drives the PC register's byte write/output enables so the PC is reloaded from the selected vector. Sits between the instruction decoder, the PC register, the stack pointer and the system bus.

## Interface
Parameters:
- ADDR_N, 16, address width
- DATA_N, 8, data width
- VEC_NMI, 16'hFFFA, NMI vector low-byte address
- VEC_RST, 16'hFFFC, reset vector low-byte address
- VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address
- STACK_PAGE, 8'h01, stack high address byte

Ports:
- Clock and reset, carried on `sys` (sys_if):
  - sys.clk  in  1  clock
  - sys.n_reset  in  1  reset; synchronous, active-low
- Request inputs:
  - nmi_n  in  1  NMI line, falling-edge triggered
  - irq_n  in  1  IRQ line, level, active-low
  - brk  in  1  decoder flags a BRK opcode; sampled with insn_boundary
  - i_flag  in  1  interrupt-disable flag
  - insn_boundary  in  1  decoder is at an opcode fetch and may yield
- Sequence status:
  - busy  out  1  sequence in progress; decoder stalls
  - done  out  1  one-cycle pulse when the sequence completes
- PC register control:
  - pc_addr_oe  out  1  PC drives address bus; low whenever busy
  - pc_oeh, pc_oel  out  1  PC high/low byte onto the internal data bus
  - pc_weh, pc_wel  out  1  load PC high/low byte from pc_in
  - pc_in  out  DATA_N  byte loaded into PC
- Data sources:
  - dbus  in  DATA_N  internal data bus (PC byte during pushes)
  - sp  in  DATA_N  stack pointer
  - sp_dec  out  1  decrement SP
  - p_in  in  DATA_N  status register
  - set_i  out  1  set interrupt-disable flag
- System bus:
  - bus_addr  out  ADDR_N  address, valid while bus_addr_oe
  - bus_addr_oe  out  1  block drives the address bus
  - bus_we  out  1  write strobe
  - bus_wdata  out  DATA_N  write data
  - bus_rdata  in  DATA_N  read data
  - bus_ready  in  1  current bus cycle completes this clock

## Operation
- States: IDLE, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, DONE.
- Each non-IDLE, non-DONE state is one bus cycle. It holds with all outputs stable until bus_ready=1.
- NMI edge detect: nmi_n registered. A 1→0 transition sets nmi_pend. nmi_pend is cleared only when an NMI vector is taken. A low level alone never re-triggers.
- Arbitration in IDLE when insn_boundary=1, fixed priority: nmi_pend > (irq_n=0 & i_flag=0) > brk. The cause and its vector are latched at grant.
- Push states:
  - bus_addr = {STACK_PAGE, sp}, bus_we=1, sp_dec=1 on completion.
  - PUSH_H: pc_oeh=1, bus_wdata=dbus.
  - PUSH_L: pc_oel=1, bus_wdata=dbus.
  - PUSH_P: bus_wdata = p_in | 8'h20, with bit 4 = 1 for BRK and 0 otherwise.
- Vector states:
  - VEC_L: bus_addr = vector, read. On bus_ready: pc_wel=1, pc_in=bus_rdata.
  - VEC_H: bus_addr = vector+1, read. On bus_ready: pc_weh=1, pc_in=bus_rdata.
  - set_i=1 for one cycle on VEC_L completion.
- NMI hijack: if nmi_pend is set while an IRQ/BRK sequence is in PUSH_H..PUSH_P, the vector switches to VEC_NMI at entry to VEC_L and nmi_pend is cleared. The pushed B bit is unchanged.
- Reset: the cycle after sys.n_reset=1 following reset, the block enters VEC_L with vector VEC_RST. It does no pushes and does not touch sp.

## Timing
- Reset values: state IDLE-pending-reset, busy=1, done=0, every strobe/enable=0, bus_addr=0, bus_wdata=0, pc_in=0, nmi_pend=0, nmi_n register=1.
- Grant at cycle T (IDLE): busy=1 from T+1.
- Zero wait states: PUSH_H T+1, PUSH_L T+2, PUSH_P T+3, VEC_L T+4, VEC_H T+5, DONE T+6.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Reset sequence: VEC_L at R+1, VEC_H at R+2, done at R+3, where R is the first cycle with n_reset=1.
- Each bus_ready=0 cycle adds exactly one cycle.
- No new grant occurs in the DONE cycle.
- sys.n_reset=0 mid-sequence aborts on the next clock edge. No partial PC write is issued after reset is sampled.
- Requests during busy: nmi edges are still captured. IRQ and BRK are ignored until IDLE.

## Structure
- Package pc_seq_pkg:
  - state_t enum
  - cause_t {C_RST, C_NMI, C_IRQ, C_BRK}
  - vector constants
  - P-register bit indices (B=4, U=5)
- Sub-module nmi_edge: registers nmi_n and holds nmi_pend, with set/clear.
- Everything else lives in one always_ff plus a combinational output decode.

## Test plan
- Reset, vector bytes FFFC=34, FFFD=12: PC writes lo 34 then hi 12; done at R+3; no bus writes.
- IRQ with i_flag=0, sp=FD, p_in=04:
  - writes to 01FD, 01FC, 01FB, with the third byte 24.
  - reads FFFE then FFFF; sp_dec pulsed 3×; done at T+6.
- BRK with IRQ masked: pushed P = p_in|30; vector FFFE.
- nmi_n falls during PUSH_L of an IRQ: reads FFFA/FFFB; nmi_pend clear afterwards; no second NMI while nmi_n stays low.
- bus_ready=0 for 2 cycles in VEC_L: address and strobes held stable; done at T+8.
- IRQ asserted with i_flag=1 and no other cause: no grant; busy stays 0.
